// File: rtl/mbc3_rtc_pkg.sv
// mbc3_rtc_pkg: register-select codes, RTC state struct and external-RAM window for the MBC3 RTC.
package mbc3_rtc_pkg;

    typedef enum logic [7:0] {
        RTC_S  = 8'h08,
        RTC_M  = 8'h09,
        RTC_H  = 8'h0A,
        RTC_DL = 8'h0B,
        RTC_DH = 8'h0C
    } rtc_reg_e;

    typedef enum logic {
        LATCH_IDLE,
        LATCH_ARMED
    } latch_state_e;

    typedef struct packed {
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic [8:0] day;
        logic       halt;
        logic       carry;
    } rtc_t;

    localparam logic [15:0] EXT_RAM_LO = 16'hA000;
    localparam logic [15:0] EXT_RAM_HI = 16'hBFFF;

    // Unused register bits read back as 1.
    function automatic logic [7:0] rtc_read(rtc_t r, rtc_reg_e sel);
        return sel == RTC_S  ? {2'b11, r.s} :
               sel == RTC_M  ? {2'b11, r.m} :
               sel == RTC_H  ? {3'b111, r.h} :
               sel == RTC_DL ? r.day[7:0] :
                               {r.carry, r.halt, 5'b11111, r.day[8]};
    endfunction

endpackage

// File: rtl/mbc3_rtc_if.sv
// mbc3_rtc_if: snooped CPU cartridge bus plus the RTC select/read-back lines.
interface mbc3_rtc_if;
    logic        wr_en;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        rtc_sel;
    logic [7:0]  rd_data;

    modport master (output wr_en, addr, wr_data, input rtc_sel, rd_data);
    modport slave  (input wr_en, addr, wr_data, output rtc_sel, rd_data);
endinterface

// File: rtl/mbc3_rtc_prescaler.sv
// mbc3_rtc_prescaler: one-second prescaler with halt and clear.
// MBC3_RTC_FAST_TICK_EN shortens a second to 4 clk cycles for simulation.
module mbc3_rtc_prescaler #(
    parameter int TICKS_PER_SEC = 4194304
) (
    input  logic clk,
    input  logic reset,
    input  logic halt,
    input  logic clear,
    output logic tick
);
`ifdef MBC3_RTC_FAST_TICK_EN
    localparam int N = 4;
`else
    localparam int N = TICKS_PER_SEC;
`endif
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign tick = !halt && cnt == W'(N - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!halt)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mbc3_rtc.sv
// mbc3_rtc: MBC3 real-time clock with snooped bank/latch controls and a latched read-back set.
// Define MBC3_RTC_FAST_TICK_EN to run seconds at 4 clk cycles (see mbc3_rtc_prescaler).
module mbc3_rtc
    import mbc3_rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4194304
) (
    input logic        clk,
    input logic        reset,
    mbc3_rtc_if.slave  bus
);
    rtc_t         live, latched;
    rtc_reg_e     sel;
    latch_state_e lstate;
    logic sel_vld, ram_en, tick, in_win, wr_rtc;
    logic wr_s, wr_m, wr_h, wr_dl, wr_dh;
    logic c_s, c_m, c_h, c_dl;

    assign in_win      = bus.addr >= EXT_RAM_LO && bus.addr <= EXT_RAM_HI;
    assign bus.rtc_sel = ram_en && sel_vld && in_win;
    assign bus.rd_data = bus.rtc_sel ? rtc_read(latched, sel) : 8'hFF;
    assign wr_rtc      = bus.wr_en && bus.rtc_sel;
    assign wr_s        = wr_rtc && sel == RTC_S;
    assign wr_m        = wr_rtc && sel == RTC_M;
    assign wr_h        = wr_rtc && sel == RTC_H;
    assign wr_dl       = wr_rtc && sel == RTC_DL;
    assign wr_dh       = wr_rtc && sel == RTC_DH;

    // A register being written this cycle swallows its own carry-out.
    assign c_s  = tick && live.s == 6'd59 && !wr_s;
    assign c_m  = c_s && live.m == 6'd59 && !wr_m;
    assign c_h  = c_m && live.h == 5'd23 && !wr_h;
    assign c_dl = c_h && live.day[7:0] == 8'hFF && !wr_dl;

    mbc3_rtc_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .halt  (live.halt),
        .clear (wr_s),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            live <= '0;
        end else begin
            if (tick)
                live.s <= live.s == 6'd59 ? 6'd0 : live.s + 6'd1;
            if (c_s)
                live.m <= live.m == 6'd59 ? 6'd0 : live.m + 6'd1;
            if (c_m)
                live.h <= live.h == 5'd23 ? 5'd0 : live.h + 5'd1;
            if (c_h)
                live.day[7:0] <= live.day[7:0] + 8'd1;
            if (c_dl)
                live.day[8] <= !live.day[8];
            if (c_dl && live.day[8] && !wr_dh)
                live.carry <= 1'b1;
            if (wr_s)
                live.s <= bus.wr_data[5:0];
            if (wr_m)
                live.m <= bus.wr_data[5:0];
            if (wr_h)
                live.h <= bus.wr_data[4:0];
            if (wr_dl)
                live.day[7:0] <= bus.wr_data;
            if (wr_dh) begin
                live.day[8] <= bus.wr_data[0];
                live.halt   <= bus.wr_data[6];
                live.carry  <= bus.wr_data[7];
            end
        end

    // Latch FSM: only an 0x00 write arms it, whatever the current state.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ram_en  <= 1'b0;
            sel_vld <= 1'b0;
            sel     <= RTC_S;
            lstate  <= LATCH_IDLE;
            latched <= '0;
        end else if (bus.wr_en) begin
            if (bus.addr[15:13] == 3'b000)
                ram_en <= bus.wr_data[3:0] == 4'hA;
            if (bus.addr[15:13] == 3'b010) begin
                sel_vld <= bus.wr_data inside {[8'h08:8'h0C]};
                if (bus.wr_data inside {[8'h08:8'h0C]})
                    sel <= rtc_reg_e'(bus.wr_data);
            end
            if (bus.addr[15:13] == 3'b011) begin
                lstate <= bus.wr_data == 8'h00 ? LATCH_ARMED : LATCH_IDLE;
                if (lstate == LATCH_ARMED && bus.wr_data == 8'h01)
                    latched <= live;
            end
        end
endmodule

// File: tb/tb_mbc3_rtc.sv
// tb_mbc3_rtc: scoreboard bench for mbc3_rtc with an integer-arithmetic reference model.
module tb_mbc3_rtc;
`ifdef MBC3_RTC_FAST_TICK_EN
    localparam int TPS = 4;
`else
    localparam int TPS = 16;
`endif

    typedef struct packed {
        int s, m, h, day, halt, carry, presc, ram_en, sel, armed;
        int ls, lm, lh, lday, lhalt, lcarry;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rd_req = 1'b0;
    int checks = 0;
    int errors = 0;
    model_t md;
    logic q_sel[$];
    logic [7:0] q_data[$];
    string q_tag[$];

    mbc3_rtc_if bus ();

    mbc3_rtc #(.TICKS_PER_SEC(TPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic model_t model_reset();
        model_t n = '0;
        n.sel = -1;
        return n;
    endfunction

    function automatic bit m_sel(model_t c, logic [15:0] a);
        return c.ram_en != 0 && c.sel >= 0 && a >= 16'hA000 && a <= 16'hBFFF;
    endfunction

    function automatic logic [7:0] m_rd(model_t c, logic [15:0] a);
        if (!m_sel(c, a)) return 8'hFF;
        case (c.sel)
            0: return {2'b11, 6'(c.ls)};
            1: return {2'b11, 6'(c.lm)};
            2: return {3'b111, 5'(c.lh)};
            3: return 8'(c.lday % 256);
            default: return {1'(c.lcarry), 1'(c.lhalt), 5'b11111, 1'(c.lday / 256)};
        endcase
    endfunction

    // One clock of the clock-chip behaviour, computed on whole numbers.
    function automatic model_t step(model_t c, logic we, logic [15:0] a, logic [7:0] d);
        model_t n = c;
        int wk;
        bit k;
        wk = (we && m_sel(c, a)) ? c.sel : -1;
        k = c.halt == 0 && c.presc == TPS - 1;
        if (we && a[15:13] == 3'd3 && c.armed != 0 && d == 8'h01) begin
            n.ls = c.s; n.lm = c.m; n.lh = c.h;
            n.lday = c.day; n.lhalt = c.halt; n.lcarry = c.carry;
        end
        n.presc = (wk == 0) ? 0 : (c.halt != 0) ? c.presc : k ? 0 : c.presc + 1;
        if (k) begin
            k = c.s == 59 && wk != 0;
            n.s = (c.s == 59) ? 0 : (c.s + 1) % 64;
        end
        if (k) begin
            k = c.m == 59 && wk != 1;
            n.m = (c.m == 59) ? 0 : (c.m + 1) % 64;
        end
        if (k) begin
            k = c.h == 23 && wk != 2;
            n.h = (c.h == 23) ? 0 : (c.h + 1) % 32;
        end
        if (k && wk != 3) begin
            if (c.day == 511 && wk != 4) n.carry = 1;
            n.day = (c.day + 1) % 512;
        end
        case (wk)
            0: n.s = int'(d[5:0]);
            1: n.m = int'(d[5:0]);
            2: n.h = int'(d[4:0]);
            3: n.day = (n.day & 256) | int'(d);
            4: begin
                n.day = (n.day & 255) | (d[0] ? 256 : 0);
                n.halt = int'(d[6]);
                n.carry = int'(d[7]);
            end
            default: ;
        endcase
        if (we) begin
            if (a[15:13] == 3'd0) n.ram_en = (d[3:0] == 4'hA) ? 1 : 0;
            if (a[15:13] == 3'd2) n.sel = (d >= 8'h08 && d <= 8'h0C) ? int'(d) - 8 : -1;
            if (a[15:13] == 3'd3) n.armed = (d == 8'h00) ? 1 : 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset)
        md <= reset ? model_reset() : step(md, bus.wr_en, bus.addr, bus.wr_data);

    // Monitor: one comparison per presented read.
    always @(negedge clk) begin
        #2;
        if (rd_req) begin
            checks++;
            if (q_data.size() == 0) begin
                errors++;
                $display("FAIL read_without_expectation: rtc_sel=%0b rd_data=%02h", bus.rtc_sel, bus.rd_data);
            end else begin
                logic es;
                logic [7:0] ed;
                string tg;
                es = q_sel.pop_front();
                ed = q_data.pop_front();
                tg = q_tag.pop_front();
                if (bus.rtc_sel !== es || bus.rd_data !== ed) begin
                    errors++;
                    $display("FAIL %s: got rtc_sel=%0b rd_data=%02h, expected rtc_sel=%0b rd_data=%02h",
                             tg, bus.rtc_sel, bus.rd_data, es, ed);
                end
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.addr = a;
        bus.wr_data = d;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a, input string tag, input logic es, input logic [7:0] ed);
        bus.addr = a;
        bus.wr_en = 1'b0;
        q_sel.push_back(es);
        q_data.push_back(ed);
        q_tag.push_back(tag);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rdm(input logic [15:0] a);
        rd(a, "random_read", m_sel(md, a), m_rd(md, a));
    endtask

    task automatic latch();
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
    endtask

    initial begin
        logic [7:0] picks [10];
        picks = '{8'd59, 8'd58, 8'd23, 8'd22, 8'hFF, 8'hFE, 8'd63, 8'd31, 8'h01, 8'h81};
        bus.wr_en = 1'b0;
        bus.addr = 16'h0000;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(16'hA000, "reset_rd", 1'b0, 8'hFF);
        wr(16'h0000, 8'h0A);
        wr(16'h4000, 8'h08);
        rd(16'hA000, "reset_latched_s", 1'b1, 8'hC0);
        // full rollover in one tick
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h40);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h09); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h0A); wr(16'hA000, 8'd23);
        wr(16'h4000, 8'h0B); wr(16'hA000, 8'hFF);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h01);
        idle(TPS);
        latch();
        wr(16'h4000, 8'h08); rd(16'hA000, "roll_s", 1'b1, 8'hC0);
        wr(16'h4000, 8'h09); rd(16'hA000, "roll_m", 1'b1, 8'hC0);
        wr(16'h4000, 8'h0A); rd(16'hA000, "roll_h", 1'b1, 8'hE0);
        wr(16'h4000, 8'h0B); rd(16'hA000, "roll_dl", 1'b1, 8'h00);
        wr(16'h4000, 8'h0C); rd(16'hA000, "roll_dh", 1'b1, 8'hBE);
        // S=63 wraps without carry
        wr(16'hA000, 8'h40);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd63);
        wr(16'h4000, 8'h09); wr(16'hA000, 8'd5);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h00);
        idle(TPS);
        latch();
        wr(16'h4000, 8'h08); rd(16'hA000, "s63_wrap", 1'b1, 8'hC0);
        wr(16'h4000, 8'h09); rd(16'hA000, "s63_m_kept", 1'b1, 8'hC5);
        wr(16'h4000, 8'h0C); rd(16'hA000, "carry_cleared", 1'b1, 8'h3E);
        // halt freezes, release resumes from frozen prescaler
        wr(16'hA000, 8'h40);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd30);
        idle(10 * TPS);
        latch();
        rd(16'hA000, "halt_frozen", 1'b1, 8'hDE);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h00);
        idle(TPS);
        latch();
        wr(16'h4000, 8'h08); rd(16'hA000, "halt_resume", 1'b1, 8'hDF);
        // latch sequences
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h40);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd10);
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h02); wr(16'h6000, 8'h01);
        rd(16'hA000, "latch_00_02_01", 1'b1, 8'hDF);
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
        rd(16'hA000, "latch_00_00_01", 1'b1, 8'hCA);
        // latch on the tick edge captures pre-tick time
        wr(16'hA000, 8'd20);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h00);
        idle(TPS - 2);
        latch();
        wr(16'h4000, 8'h08); rd(16'hA000, "latch_on_tick", 1'b1, 8'hD4);
        // select and window boundaries
        rd(16'h9FFF, "below_window", 1'b0, 8'hFF);
        rd(16'hBFFF, "window_top", 1'b1, 8'hD4);
        rd(16'hC000, "above_window", 1'b0, 8'hFF);
        wr(16'h4000, 8'h03); rd(16'hA000, "ram_bank_sel", 1'b0, 8'hFF);
        wr(16'h4000, 8'h08); rd(16'hA000, "reselect_s", 1'b1, 8'hD4);
        wr(16'h0000, 8'h00); rd(16'hA000, "ram_disabled", 1'b0, 8'hFF);
        // asynchronous reset between edges
        wr(16'h0000, 8'h0A);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        rd(16'hA000, "async_reset_sel", 1'b0, 8'hFF);
        wr(16'h0000, 8'h0A); wr(16'h4000, 8'h08);
        rd(16'hA000, "async_reset_latched", 1'b1, 8'hC0);
        // randomized traffic against the model
        for (int i = 0; i < 700; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 9))
                0: wr(16'h0000 + 16'($urandom_range(0, 16'h1FFF)),
                      $urandom_range(0, 3) == 0 ? 8'($urandom) : {4'($urandom), 4'hA});
                1: wr(16'h4000 + 16'($urandom_range(0, 16'h1FFF)),
                      $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'(8 + $urandom_range(0, 4)));
                2: wr(16'h6000 + 16'($urandom_range(0, 16'h1FFF)), 8'($urandom_range(0, 2)));
                3, 4: begin
                    d = $urandom_range(0, 1) == 0 ? picks[$urandom_range(0, 9)] : 8'($urandom);
                    if ($urandom_range(0, 3) != 0) d[6] = 1'b0;
                    wr(16'hA000 + 16'($urandom_range(0, 16'h1FFF)), d);
                end
                5, 6, 7: rdm($urandom_range(0, 4) == 0 ? 16'($urandom) : 16'hA000 + 16'($urandom_range(0, 16'h1FFF)));
                8: idle($urandom_range(1, 2 * TPS));
                default: latch();
            endcase
        end
        idle(2);
        if (q_data.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", q_data.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
